muldiv_unit: RTL

Parametrised iterative RV32M multiply/divide unit for the Execution stage. It executes all eight M-extension operations as a radix-2 shift-add / restoring-divide engine over WIDTH cycles, with special-case early completion. It drives a busy flag the pipeline uses to stall the Ex register bank, and it carries a destination-register tag through to writeback. A kill input supports pipeline flushes.

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with early completion for divide-by-zero and overflow.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             kill,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAGW-1:0]  tag_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [TAGW-1:0]  tag_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2:0]         op_q;
   logic [TAGW-1:0]    tag_q;
   logic               sa_q, sb_q;
   logic [WIDTH-1:0]   dvs;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;

   logic               accept, special, b_zero, ovf;
   logic               sgn_a, sgn_b, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b, spec_res;
   logic [WIDTH:0]     msum, shl, diff;
   logic               qbit;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo, rmd, fix_res;

   // Accept-time operand preparation and special-case detection
   always_comb begin
      sgn_a    = op[2] ? ~op[0] : (op[0] ^ op[1]);
      sgn_b    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
      sa       = sgn_a & a[WIDTH-1];
      sb       = sgn_b & b[WIDTH-1];
      mag_a    = sa ? -a : a;
      mag_b    = sb ? -b : b;
      b_zero   = (b == '0);
      ovf      = op[2] & ~op[0]
               & (a == {1'b1, {(WIDTH-1){1'b0}}})
               & (b == '1);
      special  = op[2] & (b_zero | ovf);
      spec_res = '0;
      if (b_zero)
         spec_res = op[1] ? a : '1;
      else
         spec_res = op[1] ? '0 : a;
      accept   = ((state == IDLE) | (state == DONE)) & start & ~kill;
   end

   // One iteration of the multiply and divide engines
   always_comb begin
      msum = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + ({1'b0, dvs} & {(WIDTH+1){acc[0]}});
      shl  = {rem, acc[WIDTH-1]};
      diff = shl - {1'b0, dvs};
      qbit = ~diff[WIDTH];
   end

   always_comb begin
      prod_fix = (sa_q ^ sb_q) ? -acc : acc;
      quo      = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rmd      = sa_q ? -rem : rem;
      fix_res  = '0;
      if (op_q[2])
         fix_res = op_q[1] ? rmd : quo;
      else if (op_q[1:0] == 2'b00)
         fix_res = prod_fix[WIDTH-1:0];
      else
         fix_res = prod_fix[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state == CALC) | (state == FIX);
      done     = (state == DONE);
      unique case (state)
         IDLE, DONE: begin
            if (accept)
               state_nx = special ? DONE : CALC;
            else
               state_nx = IDLE;
         end
         CALC: if (cnt == CW'(1)) state_nx = FIX;
         FIX:  state_nx = DONE;
      endcase
      if (kill)
         state_nx = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         op_q    <= '0;
         tag_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dvs     <= '0;
         acc     <= '0;
         rem     <= '0;
         result  <= '0;
         tag_out <= '0;
      end else if (!kill) begin
         if (accept) begin
            op_q  <= op;
            tag_q <= tag_in;
            sa_q  <= sa;
            sb_q  <= sb;
            cnt   <= CW'(WIDTH);
            rem   <= '0;
            if (special) begin
               result  <= spec_res;
               tag_out <= tag_in;
            end else if (op[2]) begin
               dvs <= mag_b;
               acc <= {{WIDTH{1'b0}}, mag_a};
            end else begin
               dvs <= mag_a;
               acc <= {{WIDTH{1'b0}}, mag_b};
            end
         end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            if (op_q[2]) begin
               rem <= qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
               acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qbit};
            end else begin
               acc <= {msum, acc[WIDTH-1:1]};
            end
         end else if (state == FIX) begin
            result  <= fix_res;
            tag_out <= tag_q;
         end
      end
   end

endmodule
